// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel-pair stream: field layout, pixel struct,
// unpacker state encoding and a word-half to pixel helper.
package pixel_pkg;

  localparam int unsigned FIELD_W         = 8;
  localparam int unsigned PIXEL_W         = 32;
  localparam int unsigned PIXELS_PER_WORD = 2;
  localparam int unsigned WORD_W          = PIXELS_PER_WORD * PIXEL_W;

  localparam int unsigned RED_LSB   = 16;
  localparam int unsigned GREEN_LSB = 8;
  localparam int unsigned BLUE_LSB  = 0;
  localparam int unsigned PAD_LSB   = 24;

  typedef struct packed {
    logic [FIELD_W-1:0] pad;
    logic [FIELD_W-1:0] red;
    logic [FIELD_W-1:0] green;
    logic [FIELD_W-1:0] blue;
  } pixel_t;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } unpack_state_e;

  // Split one 32-bit half of a stream word into its named fields.
  function automatic pixel_t unpack_pixel(input logic [PIXEL_W-1:0] w);
    pixel_t p;
    p.pad   = w[PAD_LSB   +: FIELD_W];
    p.red   = w[RED_LSB   +: FIELD_W];
    p.green = w[GREEN_LSB +: FIELD_W];
    p.blue  = w[BLUE_LSB  +: FIELD_W];
    return p;
  endfunction

endpackage

// File: rtl/pixel_unpack_sink_if.sv
// Word-in / pixel-out stream bundle for the pixel unpacker.
//   s_data/s_valid/s_ready : 64-bit pixel-pair word channel
//   m_red/m_green/m_blue/m_sof/m_eol/m_valid/m_ready : one-pixel-per-beat channel
// slave = the unpacker, master = the environment around it.
interface pixel_unpack_sink_if;
  import pixel_pkg::*;

  logic [WORD_W-1:0]  s_data;
  logic               s_valid;
  logic               s_ready;
  logic [FIELD_W-1:0] m_red;
  logic [FIELD_W-1:0] m_green;
  logic [FIELD_W-1:0] m_blue;
  logic               m_sof;
  logic               m_eol;
  logic               m_valid;
  logic               m_ready;

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_red, m_green, m_blue, m_sof, m_eol, m_valid
  );

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_red, m_green, m_blue, m_sof, m_eol, m_valid
  );

endinterface

// File: rtl/raster_counter.sv
// Raster position tracker: x/y advance once per accepted pixel, wrapping at
// the end of each line and frame.
//   clk, rst_n : clock, async active-low reset
//   advance    : one pixel transferred this cycle
//   x, y       : position of the pixel currently presented
//   sof, eol   : position is (0,0) / position is the last pixel of a line
module raster_counter #(
  parameter  int unsigned H_ACTIVE = 640,
  parameter  int unsigned V_ACTIVE = 480,
  localparam int unsigned XW = $clog2(H_ACTIVE),
  localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          sof,
  output logic          eol
);

  logic x_last_c;
  logic y_last_c;

  assign x_last_c = (x == XW'(H_ACTIVE - 1));
  assign y_last_c = (y == YW'(V_ACTIVE - 1));

  // Position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x_last_c) begin
        x <= '0;
        y <= y_last_c ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  assign sof = (x == '0) && (y == '0);
  assign eol = x_last_c;

endmodule

// File: rtl/pixel_unpack_sink.sv
// Pixel-pair stream sink: accepts 64-bit words holding two pixels and emits
// them one per beat, tagged with start-of-frame and end-of-line.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of the word-in / pixel-out stream bundle
//   pad_err    : sticky flag, a word with a non-zero pad byte was accepted
module pixel_unpack_sink
  import pixel_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter bit          LOW_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pixel_unpack_sink_if.slave   bus,
  output logic                 pad_err
);

  localparam int unsigned XW = $clog2(H_ACTIVE);
  localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  unpack_state_e state_q, state_d;
  logic          valid_q;
  pixel_t        pix_q;
  pixel_t        hold_q;
  pixel_t        first_c;
  pixel_t        second_c;
  logic          s_ready_c;
  logic          load_word_c;
  logic          load_second_c;
  logic          advance_c;
  logic          pad_bad_c;
  logic          raster_sof;
  logic          raster_eol;
  logic [XW-1:0] raster_x;
  logic [YW-1:0] raster_y;
  logic          unused_bits;

  // Emission order of the two halves of the incoming word.
  assign first_c  = unpack_pixel(LOW_FIRST ? bus.s_data[PIXEL_W-1:0]
                                           : bus.s_data[WORD_W-1:PIXEL_W]);
  assign second_c = unpack_pixel(LOW_FIRST ? bus.s_data[WORD_W-1:PIXEL_W]
                                           : bus.s_data[PIXEL_W-1:0]);
  assign pad_bad_c = (first_c.pad != '0) || (second_c.pad != '0);

  assign advance_c = valid_q && bus.m_ready;

  // Next state; a word is only accepted when no pixel will be left waiting.
  always_comb begin
    state_d       = state_q;
    s_ready_c     = 1'b0;
    load_word_c   = 1'b0;
    load_second_c = 1'b0;
    case (state_q)
      EMPTY: begin
        s_ready_c = 1'b1;
        if (bus.s_valid) begin
          load_word_c = 1'b1;
          state_d     = FIRST;
        end
      end
      FIRST: begin
        if (bus.m_ready) begin
          load_second_c = 1'b1;
          state_d       = SECOND;
        end
      end
      SECOND: begin
        // Refill in the same cycle the last half leaves, so no bubble.
        s_ready_c = bus.m_ready;
        if (bus.m_ready) begin
          if (bus.s_valid) begin
            load_word_c = 1'b1;
            state_d     = FIRST;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State and output-valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d != EMPTY);
    end
  end

  // Presented pixel, the parked second half, and the sticky pad flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q   <= '0;
      hold_q  <= '0;
      pad_err <= 1'b0;
    end else begin
      if (load_word_c) begin
        pix_q  <= first_c;
        hold_q <= second_c;
      end else if (load_second_c) begin
        pix_q <= hold_q;
      end
      if (load_word_c && pad_bad_c) begin
        pad_err <= 1'b1;
      end
    end
  end

  raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_raster (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (advance_c),
    .x       (raster_x),
    .y       (raster_y),
    .sof     (raster_sof),
    .eol     (raster_eol)
  );

  assign bus.s_ready = s_ready_c;
  assign bus.m_valid = valid_q;
  assign bus.m_red   = pix_q.red;
  assign bus.m_green = pix_q.green;
  assign bus.m_blue  = pix_q.blue;
  assign bus.m_sof   = valid_q && raster_sof;
  assign bus.m_eol   = valid_q && raster_eol;

  // Position and pad byte of the presented pixel are not needed downstream.
  assign unused_bits = ^{raster_x, raster_y, pix_q.pad};

endmodule
